// File: rtl/score_reader.sv
// rtl/score_reader.sv - score RAM read-back, double-dabble BCD conversion, HEX drive, session high score
//
// Periodically (and on entry to the end-of-game state) reads the score word from
// the score RAM, converts it to three BCD digits with a sequential shift-and-add-3,
// registers it for display and keeps the session high score.
//
// Ports:
//   clk        system clock
//   Reset      synchronous active-high reset
//   state      game state from the control FSM (3'b110 end of game, 3'b000 start screen)
//   wren       datapath write enable; while high the datapath owns the RAM port
//   ram_q      RAM read data
//   ram_addr   RAM address, constant SCORE_ADDR
//   ram_rden   RAM read strobe
//   score_bcd  {hundreds, tens, ones} of the last score read
//   high_bcd   BCD of the session high score
//   HEX0..HEX2 active-low seven-segment drive for ones, tens, hundreds
//   new_high   one-cycle pulse when the high score is updated
//   busy       high whenever the read FSM is not idle
module score_reader #(
  parameter int ADDR_W     = 5,
  parameter int SCORE_ADDR = 0,
  parameter int RD_LATENCY = 1,
  parameter int REFRESH    = 5000000
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [2:0]        state,
  input  logic              wren,
  input  logic [7:0]        ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic [11:0]       score_bcd,
  output logic [11:0]       high_bcd,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic              new_high,
  output logic              busy
);

  localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH - 1);
  localparam logic [1:0]    LAT_LAST = 2'(RD_LATENCY - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_BUS = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_CONVERT  = 3'd3;
  localparam logic [2:0] ST_UPDATE   = 3'd4;

  localparam logic [2:0] GAME_OVER    = 3'b110;
  localparam logic [2:0] START_SCREEN = 3'b000;

  logic [2:0]    fsm;
  logic [2:0]    fsm_nxt;
  logic [RW-1:0] ref_cnt;
  logic          refresh_hit;
  logic [2:0]    state_q;
  logic          end_game;
  logic          trigger;
  logic          pending;
  logic [1:0]    lat_cnt;
  logic          capture;
  logic [2:0]    iter;
  logic [19:0]   shreg;
  logic [19:0]   shreg_adj;
  logic [7:0]    bin_q;
  logic [7:0]    high_bin;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign ram_addr    = ADDR_W'(SCORE_ADDR);
  assign refresh_hit = (ref_cnt == REF_LAST);
  assign end_game    = (state == GAME_OVER) && (state_q != GAME_OVER);
  assign trigger     = refresh_hit || end_game;
  assign busy        = (fsm != ST_IDLE);

  // Strobe only on the first READ cycle, and never while the datapath holds the bus.
  assign ram_rden = (fsm == ST_READ) && (lat_cnt == 2'd0) && !wren;
  assign capture  = (fsm == ST_READ) && !wren && (lat_cnt == LAT_LAST);

  // Digit correction of the BCD part only; the binary part passes through untouched.
  always_comb begin
    shreg_adj = {add3(shreg[19:16]), add3(shreg[15:12]), add3(shreg[11:8]), shreg[7:0]};
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      ST_IDLE:     if (trigger) fsm_nxt = wren ? ST_WAIT_BUS : ST_READ;
      ST_WAIT_BUS: if (!wren) fsm_nxt = ST_READ;
      ST_READ: begin
        if (wren)         fsm_nxt = ST_WAIT_BUS;
        else if (capture) fsm_nxt = ST_CONVERT;
      end
      ST_CONVERT:  if (iter == 3'd7) fsm_nxt = ST_UPDATE;
      // A trigger landing in UPDATE merges with any pending one into a single follow-up read.
      ST_UPDATE: begin
        if (pending || trigger) fsm_nxt = wren ? ST_WAIT_BUS : ST_READ;
        else                    fsm_nxt = ST_IDLE;
      end
      default:     fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      fsm       <= ST_IDLE;
      ref_cnt   <= '0;
      state_q   <= 3'd0;
      pending   <= 1'b0;
      lat_cnt   <= 2'd0;
      iter      <= 3'd0;
      shreg     <= 20'd0;
      bin_q     <= 8'd0;
      high_bin  <= 8'd0;
      score_bcd <= 12'd0;
      high_bcd  <= 12'd0;
      new_high  <= 1'b0;
      HEX0      <= 7'b1000000;
      HEX1      <= 7'b1000000;
      HEX2      <= 7'b1000000;
    end else begin
      fsm     <= fsm_nxt;
      state_q <= state;
      ref_cnt <= refresh_hit ? '0 : ref_cnt + RW'(1);

      if (fsm == ST_UPDATE)
        pending <= 1'b0;
      else if (trigger && (fsm != ST_IDLE))
        pending <= 1'b1;

      lat_cnt <= ((fsm == ST_READ) && !wren && !capture) ? lat_cnt + 2'd1 : 2'd0;
      iter    <= (fsm == ST_CONVERT) ? iter + 3'd1 : 3'd0;

      if (capture) begin
        shreg <= {12'd0, ram_q};
        bin_q <= ram_q;
      end else if (fsm == ST_CONVERT) begin
        shreg <= shreg_adj << 1;
      end

      // The start screen blanks the score every cycle and overrides any UPDATE result.
      if (state == START_SCREEN)
        score_bcd <= 12'd0;
      else if (fsm == ST_UPDATE)
        score_bcd <= shreg[19:8];

      new_high <= 1'b0;
      if ((fsm == ST_UPDATE) && (state != START_SCREEN) && (bin_q > high_bin)) begin
        high_bin <= bin_q;
        high_bcd <= shreg[19:8];
        new_high <= 1'b1;
      end

      HEX0 <= seg7(score_bcd[3:0]);
      HEX1 <= seg7(score_bcd[7:4]);
      HEX2 <= seg7(score_bcd[11:8]);
    end
  end

endmodule

// File: tb/tb_score_reader.sv
// tb/tb_score_reader.sv - scoreboard bench for score_reader with a RAM model and random score values
module tb_score_reader;

  localparam int ADDR_W     = 5;
  localparam int SCORE_ADDR = 0;
  localparam int RD_LATENCY = 1;
  localparam int REFRESH    = 200;

  logic              clk = 1'b0;
  logic              Reset;
  logic [2:0]        state;
  logic              wren;
  logic [7:0]        ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [11:0]       score_bcd;
  logic [11:0]       high_bcd;
  logic [6:0]        HEX0, HEX1, HEX2;
  logic              new_high;
  logic              busy;

  score_reader #(
    .ADDR_W(ADDR_W), .SCORE_ADDR(SCORE_ADDR), .RD_LATENCY(RD_LATENCY), .REFRESH(REFRESH)
  ) dut (
    .clk(clk), .Reset(Reset), .state(state), .wren(wren), .ram_q(ram_q),
    .ram_addr(ram_addr), .ram_rden(ram_rden), .score_bcd(score_bcd), .high_bcd(high_bcd),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .new_high(new_high), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // RAM model: data is only valid RD_LATENCY-1 cycles after the strobe cycle, garbage otherwise.
  logic [7:0] mem_word = 8'd0;
  logic [7:0] garbage  = 8'd0;
  logic [3:0] rd_pipe  = 4'd0;
  logic [4:0] rd_hist;
  assign rd_hist = {rd_pipe, ram_rden};
  assign ram_q   = rd_hist[RD_LATENCY-1] ? mem_word : garbage;
  always @(posedge clk) rd_pipe <= {rd_pipe[2:0], ram_rden};
  always @(negedge clk) garbage <= 8'($urandom);

  // Reference model: one expected result per read episode.
  typedef struct {
    logic [11:0] score;
    logic [11:0] high;
    int          nh;
  } exp_t;
  exp_t sbq[$];
  int   model_high = 0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    return (d < 4'd10) ? tab[d] : 7'b1111111;
  endfunction

  task automatic push_read(input int v);
    exp_t e;
    if (state == 3'b000) begin
      e.score = 12'h000;
      e.nh    = 0;
    end else begin
      e.score = to_bcd(v);
      e.nh    = (v > model_high) ? 1 : 0;
      if (v > model_high) model_high = v;
    end
    e.high = to_bcd(model_high);
    sbq.push_back(e);
  endtask

  // Periodic reads: one every REFRESH cycles counted from reset release.
  int phase = 0;
  always @(posedge clk) begin
    if (Reset) phase <= 0;
    else if (phase == REFRESH - 1) begin
      phase <= 0;
      push_read(int'(mem_word));
    end else phase <= phase + 1;
  end

  // Monitor: each return to idle closes one read episode.
  logic        prev_busy   = 1'b0;
  logic        hex_pending = 1'b0;
  logic [11:0] hex_exp     = 12'h000;
  int          nh_seen     = 0;
  int          rden_cnt    = 0;
  exp_t        got;
  always @(negedge clk) begin
    check("rden_while_wren", {31'd0, wren && ram_rden}, 32'd0);
    if (ram_rden) rden_cnt++;
    if (Reset) begin
      prev_busy   = 1'b0;
      hex_pending = 1'b0;
      nh_seen     = 0;
    end else begin
      if (new_high) nh_seen++;
      if (prev_busy && !busy) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_read: score_bcd=0x%0h with no expected read at %0t", score_bcd, $time);
        end else begin
          got = sbq.pop_front();
          check("score_bcd", 32'(score_bcd), 32'(got.score));
          check("high_bcd", 32'(high_bcd), 32'(got.high));
          check("new_high_pulses", nh_seen, got.nh);
          hex_exp     = got.score;
          hex_pending = 1'b1;
        end
        nh_seen = 0;
      end else if (hex_pending) begin
        check("hex0", 32'(HEX0), 32'(seg_of(hex_exp[3:0])));
        check("hex1", 32'(HEX1), 32'(seg_of(hex_exp[7:4])));
        check("hex2", 32'(HEX2), 32'(seg_of(hex_exp[11:8])));
        hex_pending = 1'b0;
      end
      prev_busy = busy;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!(sbq.size() == 0 && !busy && !hex_pending) && k < 600) begin
      tick();
      k++;
    end
    if (k >= 600) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_done: timeout, queue=%0d busy=%0b", sbq.size(), busy);
    end
  endtask

  // Start a directed read only where no periodic read can collide with it.
  task automatic wait_safe();
    int k = 0;
    wait_done();
    while (!(phase >= 20 && phase <= 140 && !busy) && k < 600) begin
      tick();
      k++;
    end
    if (k >= 600) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_safe: timeout, phase=%0d busy=%0b", phase, busy);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    sbq.delete();
    model_high = 0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_score"}, 32'(score_bcd), 32'h000);
    check({tag, "_high"}, 32'(high_bcd), 32'h000);
    check({tag, "_hex0"}, 32'(HEX0), 32'(7'b1000000));
    check({tag, "_hex1"}, 32'(HEX1), 32'(7'b1000000));
    check({tag, "_hex2"}, 32'(HEX2), 32'(7'b1000000));
    check({tag, "_new_high"}, 32'(new_high), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rden"}, 32'(ram_rden), 32'd0);
    check({tag, "_addr"}, 32'(ram_addr), SCORE_ADDR);
  endtask

  task automatic end_game_read(input int v);
    mem_word = 8'(v);
    state    = 3'b110;
    push_read(v);
    tick();
    state = 3'b001;
  endtask

  initial begin
    Reset = 1'b1;
    state = 3'b001;
    wren  = 1'b0;
    tick(2);
    do_reset();
    check_reset_outputs("reset");

    // RAM holds 0: the first periodic read shows 000 without a new-high pulse.
    tick(REFRESH + 20);
    wait_done();

    // 237: exact latency from the trigger edge.
    wait_safe();
    end_game_read(237);
    tick(9);
    check("latency_early", 32'(score_bcd), 32'h000);
    tick();
    check("latency_exact", 32'(score_bcd), 32'h237);
    wait_done();

    // Random scores, some with the datapath holding the bus across the trigger.
    for (int i = 0; i < 12; i++) begin
      int v;
      int hold;
      wait_safe();
      v    = int'($urandom_range(0, 255));
      hold = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 15)) : 0;
      if (hold > 0) wren = 1'b1;
      end_game_read(v);
      if (hold > 0) begin
        tick(hold);
        wren = 1'b0;
      end
      wait_done();
    end

    // 255 then 100: high stays 255.
    wait_safe();
    end_game_read(255);
    wait_done();
    wait_safe();
    end_game_read(100);
    wait_done();
    check("high_kept_255", 32'(high_bcd), 32'h255);

    // wren held 20 cycles across a trigger.
    wait_safe();
    wren = 1'b1;
    tick(5);
    end_game_read(42);
    tick(14);
    wren = 1'b0;
    #1;
    check("wait_bus_rden_low", 32'(ram_rden), 32'd0);
    check("wait_bus_busy", 32'(busy), 32'd1);
    tick();
    check("rden_after_wren", 32'(ram_rden), 32'd1);
    wait_done();

    // wren rises in the READ cycle: the read is discarded and redone with new data.
    wait_safe();
    end_game_read(60);
    wren = 1'b1;
    sbq.delete();
    model_high = 255;
    push_read(200);
    mem_word = 8'd200;
    tick(4);
    wren = 1'b0;
    wait_done();

    // End-of-game during CONVERT: exactly one follow-up read right after UPDATE.
    wait_safe();
    rden_cnt = 0;
    end_game_read(77);
    tick(3);
    state = 3'b110;
    tick();
    state = 3'b001;
    tick(6);
    check("pending_rden", 32'(ram_rden), 32'd1);
    wait_done();
    check("pending_rden_count", rden_cnt, 2);

    // Reset mid-CONVERT with a 150 high score, then start-screen behaviour.
    do_reset();
    wait_safe();
    end_game_read(150);
    wait_done();
    check("high_150", 32'(high_bcd), 32'h150);
    state = 3'b000;
    tick();
    check("start_screen_score", 32'(score_bcd), 32'h000);
    check("start_screen_high", 32'(high_bcd), 32'h150);
    mem_word = 8'd90;
    tick(REFRESH + 20);
    wait_done();
    state = 3'b001;
    wait_safe();
    end_game_read(200);
    tick(3);
    do_reset();
    check_reset_outputs("abort");
    state = 3'b000;
    tick(3);
    check("post_reset_score", 32'(score_bcd), 32'h000);
    check("post_reset_high", 32'(high_bcd), 32'h000);

    check("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
